// File: rtl/isqrt_sum_sq_feeder.sv
// Sum-of-squares front-end for the isqrt pipeline: accepts a group of terms,
// squares and accumulates them one per cycle on a single multiplier, then pulses x_vld_o.
module isqrt_sum_sq_feeder #(
  parameter int N_TERMS   = 3,
  parameter int ARG_WIDTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           arg_vld_i,
  output logic                           arg_rdy_o,
  input  logic [N_TERMS*ARG_WIDTH-1:0]   args_i,
  output logic                           x_vld_o,
  output logic [31:0]                    x_o,
  output logic                           x_sat_o
);

  localparam int K_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int SQ_W  = 2 * ARG_WIDTH;
  localparam int ACC_W = SQ_W + 3;
  // Sum is widened to at least 33 bits so the saturation test is uniform for any ARG_WIDTH.
  localparam int SUM_W = (ACC_W > 33) ? ACC_W : 33;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_TERMS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  state_e                         state_q;
  logic                           arg_rdy_q;
  logic [N_TERMS*ARG_WIDTH-1:0]   args_q;
  logic [ACC_W-1:0]               acc_q;
  logic [K_W-1:0]                 k_q;
  logic                           x_vld_q;
  logic [31:0]                    x_q;
  logic                           x_sat_q;

  logic [ARG_WIDTH-1:0]           term_s;
  logic [SQ_W-1:0]                sq_s;
  logic [ACC_W-1:0]               acc_d;
  logic [SUM_W-1:0]               sum_s;
  logic                           sat_s;
  logic [31:0]                    x_d;

  // Select the current term from the latched group and square it.
  always_comb begin
    term_s = args_q[ARG_WIDTH-1:0];
    for (int i = 1; i < N_TERMS; i++) begin
      term_s = (k_q == K_W'(i)) ? args_q[i*ARG_WIDTH +: ARG_WIDTH] : term_s;
    end
    sq_s  = SQ_W'(term_s) * SQ_W'(term_s);
    acc_d = acc_q + ACC_W'(sq_s);
    sum_s = SUM_W'(acc_d);
    sat_s = |sum_s[SUM_W-1:32];
    x_d   = sat_s ? 32'hFFFF_FFFF : sum_s[31:0];
  end

  // Control FSM, accumulator and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      arg_rdy_q <= 1'b1;
      args_q    <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      x_vld_q   <= 1'b0;
      x_q       <= 32'h0000_0000;
      x_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          x_vld_q <= 1'b0;
          if (arg_vld_i && arg_rdy_q) begin
            args_q    <= args_i;
            acc_q     <= '0;
            k_q       <= '0;
            state_q   <= ST_ACC;
            arg_rdy_q <= 1'b0;
          end else begin
            state_q   <= ST_IDLE;
            arg_rdy_q <= 1'b1;
          end
        end
        ST_ACC: begin
          acc_q <= acc_d;
          k_q   <= k_q + K_W'(1);
          if (k_q == K_LAST) begin
            x_q       <= x_d;
            x_sat_q   <= sat_s;
            x_vld_q   <= 1'b1;
            state_q   <= ST_IDLE;
            arg_rdy_q <= 1'b1;
          end else begin
            x_vld_q   <= 1'b0;
            state_q   <= ST_ACC;
            arg_rdy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          arg_rdy_q <= 1'b1;
          x_vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign arg_rdy_o = arg_rdy_q;
  assign x_vld_o   = x_vld_q;
  assign x_o       = x_q;
  assign x_sat_o   = x_sat_q;

endmodule

// File: tb/tb_isqrt_sum_sq_feeder.sv
// Directed bench for isqrt_sum_sq_feeder with hand-computed sums of squares.
module tb_isqrt_sum_sq_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        arg_vld_i;
  logic        arg_rdy_o;
  logic [47:0] args_i;
  logic        x_vld_o;
  logic [31:0] x_o;
  logic        x_sat_o;

  int n_checks = 0;
  int n_fails  = 0;

  isqrt_sum_sq_feeder #(.N_TERMS(3), .ARG_WIDTH(16)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arg_vld_i (arg_vld_i),
    .arg_rdy_o (arg_rdy_o),
    .args_i    (args_i),
    .x_vld_o   (x_vld_o),
    .x_o       (x_o),
    .x_sat_o   (x_sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One handshake, then wait (bounded) for the x_vld pulse and check latency and result.
  task automatic run_group(input string tag, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2, input logic [31:0] exp_x, input logic exp_sat);
    int lat;
    @(negedge clk_i);
    check_eq({tag, "_rdy"}, {63'd0, arg_rdy_o}, 64'd1);
    args_i    = {t2, t1, t0};
    arg_vld_i = 1'b1;
    @(negedge clk_i);
    arg_vld_i = 1'b0;
    args_i    = {$urandom(), $urandom()};
    lat = 1;
    while (x_vld_o !== 1'b1 && lat < 12) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd4);
    check_eq({tag, "_x"}, {32'd0, x_o}, {32'd0, exp_x});
    check_eq({tag, "_sat"}, {63'd0, x_sat_o}, {63'd0, exp_sat});
    @(negedge clk_i);
    check_eq({tag, "_pulse"}, {63'd0, x_vld_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_i     = 1'b1;
    arg_vld_i = 1'b0;
    args_i    = 48'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("rst_vld", {63'd0, x_vld_o}, 64'd0);
    check_eq("rst_x", {32'd0, x_o}, 64'd0);
    check_eq("rst_sat", {63'd0, x_sat_o}, 64'd0);
    check_eq("rst_rdy", {63'd0, arg_rdy_o}, 64'd1);

    run_group("basic", 16'd3, 16'd4, 16'd0, 32'd25, 1'b0);
    run_group("sat_all", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 1'b1);
    run_group("edge_fit", 16'hFFFF, 16'h016A, 16'h0000, 32'hFFFF_FFE5, 1'b0);
    run_group("edge_ovf", 16'hFFFF, 16'h016B, 16'h0000, 32'hFFFF_FFFF, 1'b1);
    run_group("zero", 16'd0, 16'd0, 16'd0, 32'd0, 1'b0);

    // Back-to-back with arg_vld held high; args change during ACC.
    @(negedge clk_i);
    args_i    = {16'd2, 16'd2, 16'd1};
    arg_vld_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (c == 1) args_i = {16'd6, 16'd3, 16'd2};
      if (c == 5) begin
        arg_vld_i = 1'b0;
        args_i    = {16'hAAAA, 16'h5555, 16'h1234};
      end
      if (c == 4 || c == 8) begin
        check_eq($sformatf("b2b_vld_c%0d", c), {63'd0, x_vld_o}, 64'd1);
        check_eq($sformatf("b2b_x_c%0d", c), {32'd0, x_o}, (c == 4) ? 64'd9 : 64'd49);
        check_eq($sformatf("b2b_rdy_c%0d", c), {63'd0, arg_rdy_o}, 64'd1);
      end else begin
        check_eq($sformatf("b2b_vld_c%0d", c), {63'd0, x_vld_o}, 64'd0);
        check_eq($sformatf("b2b_rdy_c%0d", c), {63'd0, arg_rdy_o}, 64'd0);
      end
    end

    // Reset two cycles after the handshake aborts the group.
    @(negedge clk_i);
    args_i    = {16'd5, 16'd5, 16'd5};
    arg_vld_i = 1'b1;
    @(negedge clk_i);
    arg_vld_i = 1'b0;
    rst_i     = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("abort_vld", {63'd0, x_vld_o}, 64'd0);
    check_eq("abort_x", {32'd0, x_o}, 64'd0);
    check_eq("abort_sat", {63'd0, x_sat_o}, 64'd0);
    check_eq("abort_rdy", {63'd0, arg_rdy_o}, 64'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (x_vld_o === 1'b1) seen++;
    end
    check_eq("abort_no_pulse", 64'(seen), 64'd0);
    run_group("after_rst", 16'd0, 16'd0, 16'd7, 32'd49, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/isqrt_sum_sq_feeder.md
# isqrt_sum_sq_feeder

Sequential front-end for the `isqrt` pipeline. It accepts a group of unsigned terms through a valid/ready handshake and sums their squares over several cycles using a single multiplier. It then issues the 32-bit sum as a one-cycle `x_vld`/`x` pulse that drives `isqrt.x_vld`/`isqrt.x` directly. It is the upstream stage in the sqrt(a²+b²+c²) formula datapath.

## Interface
- `n_terms`, 3: number of terms squared and summed per transaction; legal range 1..4.
- `arg_width`, 16: width of each unsigned term; legal range 1..16.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `arg_vld`  in  1  upstream has a valid term group on `args`.
- `arg_rdy`  out  1  block can accept a group this cycle.
- `args`  in  n_terms*arg_width  packed terms; term k sits at `args[k*arg_width +: arg_width]`.
- `x_vld`  out  1  one-cycle pulse; `x` and `x_sat` are valid; wired to `isqrt.x_vld`.
- `x`  out  32  sum of squares, saturated to 32 bits; wired to `isqrt.x`.
- `x_sat`  out  1  set when the exact sum exceeded 32'hFFFF_FFFF and `x` was clamped.

## Operation
- States:
  - IDLE: `arg_rdy`=1.
  - ACC: `arg_rdy`=0.
- Term index `k` is a counter of width clog2(n_terms), minimum 1 bit.
- Accumulator `acc` is internal, 2*arg_width+3 bits wide, so no internal wrap is possible.
- IDLE:
  - Handshake occurs when `arg_vld` && `arg_rdy` at a rising edge.
  - On handshake: latch `args` into an internal register, clear `acc`, set `k`=0, go to ACC.
  - Without a handshake, stay in IDLE. `args` is don't-care when `arg_vld`=0.
- ACC, one term per cycle:
  - Each cycle: `acc` <= `acc` + term[k]*term[k], using the single arg_width×arg_width multiplier, and `k` increments.
  - On the cycle that k==n_terms-1, form the final sum = `acc` + term[k]². Then:
    - If the final sum > 32'hFFFF_FFFF: `x` <= 32'hFFFF_FFFF and `x_sat` <= 1.
    - Otherwise: `x` <= final sum[31:0] and `x_sat` <= 0.
    - `x_vld` <= 1, and the state returns to IDLE.
- `x_vld` is high for exactly one cycle per accepted group. It is 0 in every other cycle.
- `x` and `x_sat` hold their last value between pulses. Consumers sample them only while `x_vld`=1.
- There is no backpressure from downstream. `isqrt` accepts every cycle, so `x_vld` never stalls.
- Exactly one transaction is in flight at a time. Groups are never dropped or reordered; a group held with `arg_rdy`=0 stays pending upstream.
- The latched copy of `args` isolates the computation from upstream changes after the handshake.

## Timing
- Reset (`rst`=1 at a rising edge):
  - State <= IDLE, `acc` <= 0, `k` <= 0.
  - `x_vld` <= 0, `x` <= 0, `x_sat` <= 0.
  - `arg_rdy` = 1 from the first cycle after reset.
- Reset mid-operation aborts the in-flight group. No `x_vld` is produced for that group.
- Latency, handshake at edge E:
  - ACC occupies the n_terms cycles after E.
  - `x_vld`=1 in the cycle starting at edge E+n_terms. For n_terms=3, `x_vld` is high in cycle T+4 when the handshake is in cycle T.
- Throughput: `arg_rdy` is 1 again in the same cycle as `x_vld`. A next group can be accepted in that cycle, so the initiation interval is n_terms+1 cycles.
- `arg_rdy` is a pure function of state; it has no combinational path from `arg_vld`.
- n_terms=1: ACC lasts one cycle, so `x_vld` follows the handshake by 2 edges.
- End-to-end `y_vld` from `isqrt` follows `x_vld` by n_pipe_stages cycles.

## Test plan
- Basic sum: n_terms=3, args=(3,4,0), single handshake → `x_vld` high once, 4 cycles after the handshake; `x`=25, `x_sat`=0. With `isqrt` attached, `y`=5.
- Saturation: args=(16'hFFFF,16'hFFFF,16'hFFFF) → `x`=32'hFFFF_FFFF, `x_sat`=1.
- Saturation boundary, sum fits: args=(16'hFFFF,16'h016A,0) → `x`=32'hFFFF_FFE5, `x_sat`=0.
- Saturation boundary, sum overflows: args=(16'hFFFF,16'h016B,0) → `x`=32'hFFFF_FFFF, `x_sat`=1.
- Back-to-back: `arg_vld` held at 1 with (1,2,2) and then (2,3,6) → handshakes at T and T+4; `x_vld` pulses at T+4 (`x`=9) and T+8 (`x`=49). `arg_rdy`=0 during T+1..T+3 and T+5..T+7. Changing `args` during ACC leaves the results unaffected.
- Reset mid-operation: assert `rst` 2 cycles after the handshake → no `x_vld` ever appears for that group. All outputs are 0 and `arg_rdy`=1 on the next cycle. A following group (0,0,7) gives `x`=49.
